// File: rtl/draw_pkg.sv
// Shared types and constants for the animated sprite drawer: screen size,
// FSM states, the ARGB ROM word layout and the built-in sprite pattern.
package draw_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam int unsigned ARGB_W  = 16;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned ALPHA_W = 4;
    localparam logic [ALPHA_W-1:0] ALPHA_OPAQUE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    typedef struct packed {
        logic [RGB_W-1:0]   rgb;
        logic [ALPHA_W-1:0] alpha;
    } argb_t;

    // Built-in sprite image used when no init file is given.
    function automatic argb_t rom_pattern(input int unsigned a);
        argb_t w;
        w.rgb   = 12'(a) ^ 12'hA5C;
        w.alpha = ((a & 32'd7) == 32'd5) ? 4'h7 : ALPHA_OPAQUE;
        return w;
    endfunction

endpackage

// File: rtl/draw_sprite_anim_if.sv
// Pixel query/response bundle between the video timing source and the sprite drawer.
interface draw_sprite_anim_if;
    import draw_pkg::*;

    logic [1:0]       gamestate;
    logic [9:0]       xx;
    logic [8:0]       yy;
    logic             vsync_tick;
    logic [9:0]       pos_x;
    logic [9:0]       pos_y;
    logic             isempty;
    logic [RGB_W-1:0] rgb;

    modport master (output gamestate, xx, yy, vsync_tick, pos_x, pos_y,
                    input  isempty, rgb);
    modport slave  (input  gamestate, xx, yy, vsync_tick, pos_x, pos_y,
                    output isempty, rgb);
endinterface

// File: rtl/draw_sprite_anim_rom.sv
// Synchronous-read sprite ROM holding all animation frames back to back;
// serves the built-in pattern.
module sprite_rom
    import draw_pkg::*;
#(
    parameter int unsigned DEPTH     = 18432,
    parameter int unsigned AW        = 15,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output argb_t         data_o
);

    always_ff @(posedge clk) begin
        data_o <= (32'(addr_i) < DEPTH) ? rom_pattern(32'(addr_i)) : argb_t'('0);
    end

endmodule

// File: rtl/draw_sprite_anim.sv
// Animated sprite overlay: hit test, frame/delay sequencing and 2-clk pixel pipeline.
// Optional blinking is enabled with macro DRAW_SPRITE_BLINK_EN.
module draw_sprite_anim
    import draw_pkg::*;
#(
    parameter int unsigned SPR_W       = 72,
    parameter int unsigned SPR_H       = 64,
    parameter int unsigned FRAMES      = 4,
    parameter int unsigned FRAME_TICKS = 6,
    parameter int unsigned DELAY_TICKS = 30,
    parameter int unsigned BLINK_TICKS = 20,
    parameter logic [1:0]  SHOW_STATE  = 2'b10,
    parameter string       INIT_FILE   = ""
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       gamestate,
    input  logic [9:0]       xx,
    input  logic [8:0]       yy,
    input  logic             vsync_tick,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    output logic             isempty,
    output logic [RGB_W-1:0] rgb
);

    localparam int unsigned FRAME_WORDS = SPR_W * SPR_H;
    localparam int unsigned DEPTH       = FRAMES * FRAME_WORDS;
    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned FTW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned DW          = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;

    state_e          state_q, state_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [FTW-1:0]  ftick_q, ftick_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [9:0]      pos_x_q, pos_y_q;
    logic            hit_q, hit2_q, hit_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            show_entry;
    logic            visible;
    argb_t           rom_word;

    logic [9:0]      y_w, col;
    logic [10:0]     x_end, y_end, row;
    logic            in_x, in_y;

    // Sequencing: leaving the show gamestate wins over any vsync tick.
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        ftick_d    = ftick_q;
        frame_d    = frame_q;
        show_entry = 1'b0;
        if (gamestate != SHOW_STATE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DELAY;
                    dly_d   = '0;
                    frame_d = '0;
                end
                ST_DELAY: begin
                    if (DELAY_TICKS == 0) begin
                        state_d    = ST_SHOW;
                        show_entry = 1'b1;
                    end else if (vsync_tick) begin
                        if (dly_q == DW'(DELAY_TICKS - 1)) begin
                            state_d    = ST_SHOW;
                            show_entry = 1'b1;
                        end else begin
                            dly_d = dly_q + DW'(1);
                        end
                    end
                end
                ST_SHOW: begin
                    if (vsync_tick) begin
                        if (ftick_q == FTW'(FRAME_TICKS - 1)) begin
                            ftick_d = '0;
                            frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
                        end else begin
                            ftick_d = ftick_q + FTW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (show_entry) ftick_d = '0;
    end

`ifdef DRAW_SPRITE_BLINK_EN
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_q, blink_d;
    logic          visible_q, visible_d;

    always_comb begin
        blink_d   = blink_q;
        visible_d = visible_q;
        if (show_entry) begin
            blink_d   = '0;
            visible_d = 1'b1;
        end else if (state_q == ST_SHOW && gamestate == SHOW_STATE && vsync_tick) begin
            if (blink_q == BW'(BLINK_TICKS - 1)) begin
                blink_d   = '0;
                visible_d = ~visible_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            blink_q   <= '0;
            visible_q <= 1'b1;
        end else begin
            blink_q   <= blink_d;
            visible_q <= visible_d;
        end
    end

    assign visible = visible_q;
`else
    assign visible = 1'b1;
`endif

    // Stage 1: hit test in flipped y and ROM address, using the tear-free position.
    always_comb begin
        y_w    = 10'(SCREEN_H) - 10'(yy);
        x_end  = 11'(pos_x_q) + 11'(SPR_W);
        y_end  = 11'(pos_y_q) + 11'(SPR_H);
        in_x   = (xx >= pos_x_q) && (11'(xx) < x_end);
        in_y   = (y_w >= pos_y_q) && (11'(y_w) < y_end);
        col    = xx - pos_x_q;
        row    = y_end - 11'd1 - 11'(y_w);
        hit_d  = in_x && in_y && (state_q == ST_SHOW) && visible;
        addr_d = '0;
        if (hit_d) begin
            addr_d = AW'(32'(frame_q) * FRAME_WORDS + 32'(row) * SPR_W + 32'(col));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            ftick_q <= '0;
            frame_q <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            hit_q   <= 1'b0;
            hit2_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            ftick_q <= ftick_d;
            frame_q <= frame_d;
            if (vsync_tick) begin
                pos_x_q <= pos_x;
                pos_y_q <= pos_y;
            end
            hit_q   <= hit_d;
            hit2_q  <= hit_q;
            addr_q  <= addr_d;
        end
    end

    // Stage 2: ROM data register and hit flag line up at the outputs.
    sprite_rom #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk    (clk),
        .addr_i (addr_q),
        .data_o (rom_word)
    );

    assign isempty = ~(hit2_q && (rom_word.alpha == ALPHA_OPAQUE));
    assign rgb     = isempty ? '0 : rom_word.rgb;

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Directed bench for draw_sprite_anim with hand-computed pixel values;
// blink expectations follow macro DRAW_SPRITE_BLINK_EN.
module tb_draw_sprite_anim;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    draw_sprite_anim_if ifc ();

    draw_sprite_anim #(
        .SPR_W       (72),
        .SPR_H       (64),
        .FRAMES      (4),
        .FRAME_TICKS (6),
        .DELAY_TICKS (2),
        .BLINK_TICKS (20),
        .SHOW_STATE  (2'b10)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .gamestate  (ifc.gamestate),
        .xx         (ifc.xx),
        .yy         (ifc.yy),
        .vsync_tick (ifc.vsync_tick),
        .pos_x      (ifc.pos_x),
        .pos_y      (ifc.pos_y),
        .isempty    (ifc.isempty),
        .rgb        (ifc.rgb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int t_show   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vtick();
        ifc.vsync_tick = 1'b1;
        step(1);
        ifc.vsync_tick = 1'b0;
    endtask

    // Present a pixel, wait the two-clock latency, compare both outputs.
    task automatic probe(input string tag, input logic [9:0] x, input logic [8:0] y,
                         input logic exp_empty, input logic [11:0] exp_rgb);
        ifc.xx = x;
        ifc.yy = y;
        step(2);
        check({tag, "_empty"}, 32'(ifc.isempty), 32'(exp_empty));
        check({tag, "_rgb"},   32'(ifc.rgb),     32'(exp_rgb));
    endtask

    // Colour of the sprite's top-left texel after t ticks in SHOW (frame stride 4608 words).
    function automatic logic [11:0] origin_rgb(input int t);
        int frame;
        frame = (t / 6) % 4;
        return 12'(frame * 4608) ^ 12'hA5C;
    endfunction

    function automatic logic vis_at(input int t);
`ifdef DRAW_SPRITE_BLINK_EN
        return ((t / 20) % 2) == 0;
`else
        return (t >= 0);
`endif
    endfunction

    task automatic probe_origin(input string tag, input logic [9:0] x);
        logic vis;
        vis = vis_at(t_show);
        probe(tag, x, 9'd217, ~vis, vis ? origin_rgb(t_show) : 12'h000);
    endtask

    initial begin
        ifc.gamestate  = 2'b00;
        ifc.xx         = 10'd284;
        ifc.yy         = 9'd217;
        ifc.vsync_tick = 1'b0;
        ifc.pos_x      = 10'd284;
        ifc.pos_y      = 10'd200;

        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_empty", 32'(ifc.isempty), 32'd1);
            check("rst_rgb",   32'(ifc.rgb),     32'd0);
        end
        rstn = 1'b1;

        vtick();
        ifc.gamestate = 2'b10;
        step(1);
        probe("delay_t0", 10'd284, 9'd217, 1'b1, 12'h000);
        vtick();
        probe("delay_t1", 10'd284, 9'd217, 1'b1, 12'h000);
        vtick();
        t_show = 0;
        probe("show_origin", 10'd284, 9'd217, 1'b0, 12'hA5C);
        probe("yy201_miss",  10'd284, 9'd201, 1'b1, 12'h000);

        // Sprite spans xx 284..355 and flipped y 200..263 (yy 217..280).
        probe("x355_hit",    10'd355, 9'd217, 1'b0, 12'hA1B);
        probe("x356_miss",   10'd356, 9'd217, 1'b1, 12'h000);
        probe("x283_miss",   10'd283, 9'd217, 1'b1, 12'h000);
        probe("y264_miss",   10'd284, 9'd216, 1'b1, 12'h000);
        probe("y200_hit",    10'd284, 9'd280, 1'b0, 12'hBE4);
        probe("y199_miss",   10'd284, 9'd281, 1'b1, 12'h000);
        probe("alpha7_clear",10'd289, 9'd217, 1'b1, 12'h000);

        for (int t = 1; t <= 40; t++) begin
            vtick();
            t_show = t;
            if (t inside {5, 6, 12, 18, 19, 20, 24, 39, 40})
                probe_origin($sformatf("frame_t%0d", t), 10'd284);
        end

        ifc.pos_x = 10'd300;
        probe_origin("posx_hold", 10'd284);
        vtick();
        t_show = 41;
        probe("posx_old_miss", 10'd284, 9'd217, 1'b1, 12'h000);
        probe_origin("posx_new", 10'd300);

        ifc.gamestate  = 2'b00;
        ifc.vsync_tick = 1'b1;
        step(1);
        ifc.vsync_tick = 1'b0;
        probe("leave_idle", 10'd300, 9'd217, 1'b1, 12'h000);

        ifc.gamestate = 2'b10;
        step(1);
        probe("reenter_t0", 10'd300, 9'd217, 1'b1, 12'h000);
        vtick();
        probe("reenter_t1", 10'd300, 9'd217, 1'b1, 12'h000);
        vtick();
        t_show = 0;
        probe_origin("reenter_show", 10'd300);

        rstn = 1'b0;
        step(1);
        check("rst_mid_empty", 32'(ifc.isempty), 32'd1);
        check("rst_mid_rgb",   32'(ifc.rgb),     32'd0);
        rstn = 1'b1;
        probe("post_rst_dark", 10'd300, 9'd217, 1'b1, 12'h000);
        vtick();
        probe("post_rst_t1", 10'd300, 9'd217, 1'b1, 12'h000);
        vtick();
        t_show = 0;
        probe_origin("post_rst_show", 10'd300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
